// File: rtl/ext_mem_port_pkg.sv
// Shared types and width defaults for the external memory port.
package ext_mem_port_pkg;

  localparam int unsigned EXT_ADDR_W = 9;
  localparam int unsigned EXT_DATA_W = 16;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoadI    = 3'd1,
    StLoadD    = 3'd2,
    StRead     = 3'd3,
    StRun      = 3'd4,
    StReadWait = 3'd5
  } ext_state_t;

endpackage

// File: rtl/ext_mem_port_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module edge_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_d, level_q;

  // Next state is simply the current level.
  always_comb begin
    level_d = level_i;
  end

  // Remember last cycle's level so a held strobe fires only once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/ext_mem_port.sv
// Host-side responder for IRAM/DRAM load, DRAM readback and core run handoff.
module ext_mem_port
  import ext_mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = EXT_ADDR_W,
  parameter int unsigned DATA_W     = EXT_DATA_W,
  parameter int unsigned DRAM_DEPTH = 512,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              start_2,
  input  logic              start_3,
  input  logic              start_4,
  input  logic [ADDR_W-1:0] addr_ext,
  input  logic              iram_write_ext_1,
  input  logic              iram_write_ext_2,
  input  logic [DATA_W-1:0] Data_in_ins,
  input  logic              dram_write_ext,
  input  logic [DATA_W-1:0] Data_in_dram,
  input  logic              read_en_ext,
  output logic [DATA_W-1:0] dram_in_1,
  output logic [ADDR_W-1:0] iram1_addr,
  output logic              iram1_we,
  output logic [DATA_W-1:0] iram1_wdata,
  output logic [ADDR_W-1:0] iram2_addr,
  output logic              iram2_we,
  output logic [DATA_W-1:0] iram2_wdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic [ADDR_W-1:0] core_dram_addr,
  input  logic              core_dram_we,
  input  logic [DATA_W-1:0] core_dram_wdata,
  output logic              run_en,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wr_count,
  output logic              mode_err,
  output logic              oob_err
);

  localparam int unsigned RdCntW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic i1_edge, i2_edge, dw_edge, rd_edge;
  logic addr_oob;

  ext_state_t state_d, state_q;
  logic [ADDR_W-1:0] wr_count_d, wr_count_q;
  logic iram1_we_d, iram1_we_q, iram2_we_d, iram2_we_q, dram_we_d, dram_we_q;
  logic [ADDR_W-1:0] ins_addr_d, ins_addr_q, host_addr_d, host_addr_q;
  logic [DATA_W-1:0] ins_wdata_d, ins_wdata_q, host_wdata_d, host_wdata_q;
  logic [RdCntW-1:0] rd_cnt_d, rd_cnt_q;
  logic [DATA_W-1:0] dram_in_1_d, dram_in_1_q;
  logic rd_valid_d, rd_valid_q, mode_err_d, mode_err_q, oob_err_d, oob_err_q;

  edge_pulse u_edge_i1 (
    .clk_i  (clock),
    .rst_i  (reset),
    .level_i(iram_write_ext_1),
    .pulse_o(i1_edge)
  );

  edge_pulse u_edge_i2 (
    .clk_i  (clock),
    .rst_i  (reset),
    .level_i(iram_write_ext_2),
    .pulse_o(i2_edge)
  );

  edge_pulse u_edge_dw (
    .clk_i  (clock),
    .rst_i  (reset),
    .level_i(dram_write_ext),
    .pulse_o(dw_edge)
  );

  edge_pulse u_edge_rd (
    .clk_i  (clock),
    .rst_i  (reset),
    .level_i(read_en_ext),
    .pulse_o(rd_edge)
  );

  assign addr_oob = 32'(addr_ext) >= DRAM_DEPTH;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (&v) ? v : v + ADDR_W'(1);
  endfunction

  // Mode FSM, write/read issue and sticky error tracking.
  always_comb begin
    state_d      = state_q;
    wr_count_d   = wr_count_q;
    iram1_we_d   = 1'b0;
    iram2_we_d   = 1'b0;
    dram_we_d    = 1'b0;
    ins_addr_d   = ins_addr_q;
    ins_wdata_d  = ins_wdata_q;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    rd_cnt_d     = rd_cnt_q;
    dram_in_1_d  = dram_in_1_q;
    rd_valid_d   = 1'b0;
    mode_err_d   = mode_err_q;
    oob_err_d    = oob_err_q;

    unique case (state_q)
      StIdle: begin
        case ({start, start_2, start_3, start_4})
          4'b0000: ;
          4'b0100: begin
            state_d    = StLoadI;
            wr_count_d = '0;
          end
          4'b0010: begin
            state_d    = StLoadD;
            wr_count_d = '0;
          end
          4'b0001: state_d = StRead;
          4'b1000: state_d = StRun;
          default: mode_err_d = 1'b1;
        endcase
      end
      StLoadI: begin
        // Simultaneous edges write both IRAMs but count as one write.
        if (i1_edge || i2_edge) begin
          iram1_we_d  = i1_edge;
          iram2_we_d  = i2_edge;
          ins_addr_d  = addr_ext;
          ins_wdata_d = Data_in_ins;
          wr_count_d  = sat_inc(wr_count_q);
        end
        if (!start_2 && !i1_edge && !i2_edge && !iram1_we_q && !iram2_we_q) begin
          state_d = StIdle;
        end
      end
      StLoadD: begin
        if (dw_edge) begin
          if (addr_oob) begin
            oob_err_d = 1'b1;
          end else begin
            dram_we_d    = 1'b1;
            host_addr_d  = addr_ext;
            host_wdata_d = Data_in_dram;
            wr_count_d   = sat_inc(wr_count_q);
          end
        end
        if (!start_3 && !dw_edge && !dram_we_q) begin
          state_d = StIdle;
        end
      end
      StRead: begin
        if (rd_edge && !addr_oob) begin
          host_addr_d = addr_ext;
          rd_cnt_d    = '0;
          state_d     = StReadWait;
        end else begin
          if (rd_edge) begin
            oob_err_d = 1'b1;
          end
          if (!start_4) begin
            state_d = StIdle;
          end
        end
      end
      StReadWait: begin
        // Strobe edges here are dropped; capture once the RAM latency elapses.
        if (rd_cnt_q == RdCntW'(RD_LAT)) begin
          dram_in_1_d = dram_rdata;
          rd_valid_d  = 1'b1;
          state_d     = StRead;
        end else begin
          rd_cnt_d = rd_cnt_q + RdCntW'(1);
        end
      end
      StRun: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any pending access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_count_q   <= '0;
      iram1_we_q   <= 1'b0;
      iram2_we_q   <= 1'b0;
      dram_we_q    <= 1'b0;
      ins_addr_q   <= '0;
      ins_wdata_q  <= '0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      rd_cnt_q     <= '0;
      dram_in_1_q  <= '0;
      rd_valid_q   <= 1'b0;
      mode_err_q   <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      iram1_we_q   <= iram1_we_d;
      iram2_we_q   <= iram2_we_d;
      dram_we_q    <= dram_we_d;
      ins_addr_q   <= ins_addr_d;
      ins_wdata_q  <= ins_wdata_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      rd_cnt_q     <= rd_cnt_d;
      dram_in_1_q  <= dram_in_1_d;
      rd_valid_q   <= rd_valid_d;
      mode_err_q   <= mode_err_d;
      oob_err_q    <= oob_err_d;
    end
  end

  // Output drive; the DRAM port belongs to core 1 only while running.
  always_comb begin
    run_en      = (state_q == StRun);
    iram1_addr  = ins_addr_q;
    iram1_we    = iram1_we_q;
    iram1_wdata = ins_wdata_q;
    iram2_addr  = ins_addr_q;
    iram2_we    = iram2_we_q;
    iram2_wdata = ins_wdata_q;
    dram_addr   = run_en ? core_dram_addr : host_addr_q;
    dram_we     = run_en ? core_dram_we : dram_we_q;
    dram_wdata  = run_en ? core_dram_wdata : host_wdata_q;
    dram_in_1   = dram_in_1_q;
    rd_valid    = rd_valid_q;
    wr_count    = wr_count_q;
    mode_err    = mode_err_q;
    oob_err     = oob_err_q;
  end

endmodule

// File: tb/tb_ext_mem_port.sv
// Directed bench for ext_mem_port: vector table plus multi-cycle sequences.
module tb_ext_mem_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start, start_2, start_3, start_4;
  logic [8:0]  addr_ext;
  logic        iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext;
  logic [15:0] Data_in_ins, Data_in_dram;
  logic [15:0] dram_in_1;
  logic [8:0]  iram1_addr, iram2_addr, dram_addr;
  logic        iram1_we, iram2_we, dram_we;
  logic [15:0] iram1_wdata, iram2_wdata, dram_wdata;
  logic [15:0] dram_rdata = '0;
  logic [8:0]  core_dram_addr;
  logic        core_dram_we;
  logic [15:0] core_dram_wdata;
  logic        run_en, rd_valid, mode_err, oob_err;
  logic [8:0]  wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  ext_mem_port #(
    .ADDR_W    (9),
    .DATA_W    (16),
    .DRAM_DEPTH(256),
    .RD_LAT    (1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .start_2         (start_2),
    .start_3         (start_3),
    .start_4         (start_4),
    .addr_ext        (addr_ext),
    .iram_write_ext_1(iram_write_ext_1),
    .iram_write_ext_2(iram_write_ext_2),
    .Data_in_ins     (Data_in_ins),
    .dram_write_ext  (dram_write_ext),
    .Data_in_dram    (Data_in_dram),
    .read_en_ext     (read_en_ext),
    .dram_in_1       (dram_in_1),
    .iram1_addr      (iram1_addr),
    .iram1_we        (iram1_we),
    .iram1_wdata     (iram1_wdata),
    .iram2_addr      (iram2_addr),
    .iram2_we        (iram2_we),
    .iram2_wdata     (iram2_wdata),
    .dram_addr       (dram_addr),
    .dram_we         (dram_we),
    .dram_wdata      (dram_wdata),
    .dram_rdata      (dram_rdata),
    .core_dram_addr  (core_dram_addr),
    .core_dram_we    (core_dram_we),
    .core_dram_wdata (core_dram_wdata),
    .run_en          (run_en),
    .rd_valid        (rd_valid),
    .wr_count        (wr_count),
    .mode_err        (mode_err),
    .oob_err         (oob_err)
  );

  always #5 clock = ~clock;

  // Synchronous single-port DRAM with one cycle of read latency.
  logic [15:0] mem [512];
  always @(posedge clock) begin
    if (dram_we) mem[dram_addr] <= dram_wdata;
    dram_rdata <= mem[dram_addr];
  end

  // Pulse monitors, sampled mid-cycle.
  int cnt_i1 = 0, cnt_i2 = 0, cnt_dwe = 0, cnt_rdv = 0;
  logic [8:0]  i1_addrs [$];
  logic [15:0] i1_datas [$];
  always @(negedge clock) begin
    if (iram1_we) begin
      cnt_i1 <= cnt_i1 + 1;
      i1_addrs.push_back(iram1_addr);
      i1_datas.push_back(iram1_wdata);
    end
    if (iram2_we) cnt_i2 <= cnt_i2 + 1;
    if (dram_we) cnt_dwe <= cnt_dwe + 1;
    if (rd_valid) cnt_rdv <= cnt_rdv + 1;
  end

  typedef struct {
    logic [7:0]  strb;   // start, start_2, start_3, start_4, i1, i2, dw, re
    logic [8:0]  addr;
    logic [15:0] din;
    logic [6:0]  flags;  // iram1_we, iram2_we, dram_we, run_en, rd_valid, mode_err, oob_err
    logic [8:0]  cnt;
    logic [1:0]  chk;    // 1: check IRAM port, 2: check DRAM port
    logic [8:0]  eaddr;
    logic [15:0] edata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({dram_in_1, iram1_addr, iram1_we, iram1_wdata, iram2_addr, iram2_we,
                 iram2_wdata, dram_addr, dram_we, dram_wdata, run_en, rd_valid, wr_count,
                 mode_err, oob_err});
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    {start, start_2, start_3, start_4} = 4'b0;
    {iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext} = 4'b0;
    addr_ext = '0;
    Data_in_ins = '0;
    Data_in_dram = '0;
    core_dram_addr = '0;
    core_dram_we = 1'b0;
    core_dram_wdata = '0;
  endtask

  task automatic do_reset(input string name);
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk(name, all_outs(), 128'(0));
  endtask

  logic [4:0] rdv_hist;
  int b0, b1;

  initial begin
    vecs[0]  = '{8'b0000_0000, 9'd0,   16'd0,      7'b0000000, 9'd0, 2'd0, 9'd0, 16'd0};
    vecs[1]  = '{8'b0100_0000, 9'd0,   16'd0,      7'b0000000, 9'd0, 2'd0, 9'd0, 16'd0};
    vecs[2]  = '{8'b0100_1000, 9'd1,   16'd10,     7'b1000000, 9'd1, 2'd1, 9'd1, 16'd10};
    vecs[3]  = '{8'b0100_1000, 9'd1,   16'd10,     7'b0000000, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[4]  = '{8'b0100_0000, 9'd1,   16'd10,     7'b0000000, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[5]  = '{8'b0100_1100, 9'd2,   16'd20,     7'b1100000, 9'd2, 2'd1, 9'd2, 16'd20};
    vecs[6]  = '{8'b0100_0010, 9'd2,   16'd20,     7'b0000000, 9'd2, 2'd0, 9'd0, 16'd0};
    vecs[7]  = '{8'b0000_0000, 9'd0,   16'd0,      7'b0000000, 9'd2, 2'd0, 9'd0, 16'd0};
    vecs[8]  = '{8'b0010_0000, 9'd0,   16'd0,      7'b0000000, 9'd0, 2'd0, 9'd0, 16'd0};
    vecs[9]  = '{8'b0010_0010, 9'd5,   16'hBEEF,   7'b0010000, 9'd1, 2'd2, 9'd5, 16'hBEEF};
    vecs[10] = '{8'b0010_0000, 9'd5,   16'hBEEF,   7'b0000000, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[11] = '{8'b0010_0010, 9'd300, 16'h1111,   7'b0000001, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[12] = '{8'b0000_0000, 9'd0,   16'd0,      7'b0000001, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[13] = '{8'b0110_0000, 9'd0,   16'd0,      7'b0000011, 9'd1, 2'd0, 9'd0, 16'd0};
    vecs[14] = '{8'b0000_0000, 9'd0,   16'd0,      7'b0000011, 9'd1, 2'd0, 9'd0, 16'd0};

    // Cycle-by-cycle vector table.
    do_reset("reset_tbl");
    for (int i = 0; i < 15; i++) begin
      {start, start_2, start_3, start_4,
       iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext} = vecs[i].strb;
      addr_ext = vecs[i].addr;
      Data_in_ins = vecs[i].din;
      Data_in_dram = vecs[i].din;
      step();
      chk($sformatf("row%0d_flags", i),
          128'({iram1_we, iram2_we, dram_we, run_en, rd_valid, mode_err, oob_err}),
          128'(vecs[i].flags));
      chk($sformatf("row%0d_wr_count", i), 128'(wr_count), 128'(vecs[i].cnt));
      if (vecs[i].chk == 2'd1) begin
        chk($sformatf("row%0d_iram_port", i),
            128'({iram1_addr, iram1_wdata, iram2_addr, iram2_wdata}),
            128'({vecs[i].eaddr, vecs[i].edata, vecs[i].eaddr, vecs[i].edata}));
      end else if (vecs[i].chk == 2'd2) begin
        chk($sformatf("row%0d_dram_port", i), 128'({dram_addr, dram_wdata}),
            128'({vecs[i].eaddr, vecs[i].edata}));
      end
    end

    // IRAM1 load with strobes held for four cycles each.
    do_reset("reset_iram");
    start_2 = 1'b1;
    step();
    b0 = cnt_i1;
    b1 = cnt_i2;
    for (int i = 1; i <= 3; i++) begin
      addr_ext = 9'(i);
      Data_in_ins = 16'(10 * i);
      iram_write_ext_1 = 1'b1;
      repeat (4) step();
      iram_write_ext_1 = 1'b0;
      step();
    end
    chk("iram1_pulses", 128'(cnt_i1 - b0), 128'(3));
    chk("iram2_pulses", 128'(cnt_i2 - b1), 128'(0));
    chk("iram_wr_count", 128'(wr_count), 128'(3));
    for (int j = 0; j < 3; j++) begin
      if (i1_addrs.size() > b0 + j) begin
        chk($sformatf("iram1_write%0d", j), 128'({i1_addrs[b0 + j], i1_datas[b0 + j]}),
            128'({9'(j + 1), 16'(10 * (j + 1))}));
      end
    end
    start_2 = 1'b0;
    repeat (2) step();

    // DRAM load then readback timing.
    do_reset("reset_read");
    start_3 = 1'b1;
    step();
    addr_ext = 9'd5;
    Data_in_dram = 16'hBEEF;
    dram_write_ext = 1'b1;
    step();
    dram_write_ext = 1'b0;
    step();
    start_3 = 1'b0;
    repeat (2) step();
    start_4 = 1'b1;
    step();
    b0 = cnt_rdv;
    read_en_ext = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      rdv_hist[j] = rd_valid;
    end
    chk("rd_valid_timing", 128'(rdv_hist), 128'(5'b00100));
    chk("rd_valid_pulses", 128'(cnt_rdv - b0), 128'(1));
    chk("readback_data", 128'(dram_in_1), 128'(16'hBEEF));
    read_en_ext = 1'b0;
    step();
    addr_ext = 9'd300;
    read_en_ext = 1'b1;
    repeat (4) step();
    chk("oob_read_err", 128'(oob_err), 128'(1));
    chk("oob_read_no_valid", 128'(cnt_rdv - b0), 128'(1));
    chk("oob_read_hold", 128'(dram_in_1), 128'(16'hBEEF));
    read_en_ext = 1'b0;
    start_4 = 1'b0;
    repeat (2) step();

    // Run handoff: core owns the DRAM port, host strobes are ignored.
    do_reset("reset_run");
    core_dram_addr = 9'd7;
    core_dram_we = 1'b1;
    core_dram_wdata = 16'd42;
    start = 1'b1;
    step();
    chk("run_port", 128'({run_en, dram_addr, dram_we, dram_wdata}),
        128'({1'b1, 9'd7, 1'b1, 16'd42}));
    core_dram_we = 1'b0;
    b0 = cnt_dwe;
    for (int j = 0; j < 3; j++) begin
      dram_write_ext = 1'b1;
      step();
      dram_write_ext = 1'b0;
      step();
    end
    chk("run_no_host_write", 128'(cnt_dwe - b0), 128'(0));
    start = 1'b0;
    core_dram_addr = '0;
    core_dram_wdata = '0;
    repeat (2) step();
    chk("run_exit", 128'(run_en), 128'(0));

    // Reset lands between the strobe edge and its write cycle.
    do_reset("reset_pre_abort");
    start_3 = 1'b1;
    step();
    addr_ext = 9'd9;
    Data_in_dram = 16'h1234;
    b0 = cnt_dwe;
    dram_write_ext = 1'b1;
    #2;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_outputs_zero", all_outs(), 128'(0));
    repeat (3) step();
    chk("abort_no_write", 128'(cnt_dwe - b0), 128'(0));
    clear_inputs();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_mem_port.md
Name: ext_mem_port

Overview:
- External-side responder for the host load/readback protocol of the multicore top: `start_2` loads IRAM, `start_3` loads DRAM, `start_4` reads DRAM back, `start` runs the cores.
- Turns level-held host write/read strobes into exactly one memory access per strobe.
- Muxes the shared DRAM port between the host and core 1, and gates core run enable.
- Sits between the top-level pins and the IRAM1/IRAM2/DRAM instances inside `top_control_2`.

Parameters:
- `ADDR_W`, 9, external/memory address width.
- `DATA_W`, 16, instruction and data word width.
- `DRAM_DEPTH`, 512, valid DRAM words; host addresses >= `DRAM_DEPTH` are rejected.
- `RD_LAT`, 1, DRAM read latency in cycles (synchronous RAM).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: run request.
- `start_2` in 1: IRAM load mode request.
- `start_3` in 1: DRAM load mode request.
- `start_4` in 1: DRAM readback mode request.
- `addr_ext` in `ADDR_W`: host address.
- `iram_write_ext_1` in 1: host write strobe, IRAM1.
- `iram_write_ext_2` in 1: host write strobe, IRAM2.
- `Data_in_ins` in `DATA_W`: host instruction word.
- `dram_write_ext` in 1: host write strobe, DRAM.
- `Data_in_dram` in `DATA_W`: host data word.
- `read_en_ext` in 1: host read strobe.
- `dram_in_1` out `DATA_W`: readback word to host.
- `iram1_addr` out `ADDR_W`, `iram1_we` out 1, `iram1_wdata` out `DATA_W`: IRAM1 write port.
- `iram2_addr` out `ADDR_W`, `iram2_we` out 1, `iram2_wdata` out `DATA_W`: IRAM2 write port.
- `dram_addr` out `ADDR_W`, `dram_we` out 1, `dram_wdata` out `DATA_W`: DRAM port.
- `dram_rdata` in `DATA_W`: DRAM read data.
- `core_dram_addr` in `ADDR_W`, `core_dram_we` in 1, `core_dram_wdata` in `DATA_W`: core-1 DRAM request.
- `run_en` out 1: cores enabled.
- `rd_valid` out 1: one-cycle pulse when `dram_in_1` updates.
- `wr_count` out `ADDR_W`: writes accepted in the current load mode (saturating).
- `mode_err` out 1: sticky conflicting-request flag.
- `oob_err` out 1: sticky out-of-range access flag.

Behaviour:
- Reset values: all outputs 0; FSM in `IDLE`; edge-detect registers cleared. Reset mid-access aborts the access; no write is issued after reset deasserts.
- FSM states: `IDLE`, `LOAD_I`, `LOAD_D`, `READ`, `RUN`, `READ_WAIT`.
- Transitions from `IDLE` require exactly one request high:
  - `start_2` -> `LOAD_I`
  - `start_3` -> `LOAD_D`
  - `start_4` -> `READ`
  - `start` -> `RUN`
- Two or more requests high in `IDLE`: set `mode_err`, stay in `IDLE`.
- A mode returns to `IDLE` the cycle after its request drops. If a write or read is in flight, the return waits until it completes.
- Entering `LOAD_I` or `LOAD_D` clears `wr_count`.
- Strobes are rising-edge detected on registered copies. A strobe held high for N cycles yields exactly one access.
- Write latency: strobe edge seen at clock edge k -> address/data sampled at k -> memory write enable high for the single cycle k+1.
- `LOAD_I`:
  - `iram_write_ext_1` edge -> `iram1_we`; `iram_write_ext_2` edge -> `iram2_we`.
  - Both edges in the same cycle -> both IRAMs are written, and `wr_count` increments by 1.
- `LOAD_D`: `dram_write_ext` edge -> `dram_we`.
- `wr_count` increments by 1 per accepted write and saturates at all-ones.
- Strobes outside their mode are ignored. Example: `dram_write_ext` in `LOAD_I` causes no write.
- `READ`:
  - `read_en_ext` edge at k -> `dram_addr` = `addr_ext` at k+1, FSM enters `READ_WAIT`.
  - After `RD_LAT` cycles `dram_rdata` is captured into `dram_in_1` with `rd_valid` pulsed.
  - Return to `READ` occurs in the same cycle as the capture.
  - Further strobe edges during `READ_WAIT` are dropped.
  - `dram_in_1` holds its value until the next capture or reset.
- Out of range: a DRAM write or read with `addr_ext` >= `DRAM_DEPTH` is not issued and sets `oob_err`. A rejected read does not pulse `rd_valid`.
- `RUN`:
  - `run_en` = 1.
  - DRAM port driven from the `core_dram_*` inputs combinationally through the mux.
  - All host strobes ignored.
- All other states: `run_en` = 0; DRAM port owned by the host; `dram_we` = 0 except the issued write pulse.
- Host `dram_addr`/`dram_wdata` are registered, so the core path and host path never drive simultaneously.
- `mode_err` and `oob_err` clear only on reset.

Decomposition:
- Shared package holds:
  - FSM state enum `ext_state_t` (3-bit encoding).
  - `ADDR_W` and `DATA_W` defaults.
- Sub-module `edge_pulse`: one-register rising-edge detector with asynchronous reset, instantiated once per strobe (4 instances).

Test Plan:
- Load IRAM1: `start_2`=1; `addr_ext`=1..3, `Data_in_ins`=10,20,30, `iram_write_ext_1` held 4 cycles each -> exactly 3 `iram1_we` pulses at addr 1,2,3 with data 10,20,30; `wr_count`=3; `iram2_we` never high.
- Load DRAM then read back:
  - `start_3` load addr 5 = 16'hBEEF.
  - `start_4`, `addr_ext`=5, `read_en_ext` held 5 cycles -> `dram_in_1`=16'hBEEF with `rd_valid` high for exactly 1 cycle, 2 cycles after the strobe edge.
- Conflict: `start_2` and `start_3` both asserted in `IDLE` -> `mode_err`=1, FSM stays in `IDLE`, no writes issued.
- Run handoff: `start`=1 with core driving addr 7, we=1, data 42 -> `dram_addr`=7, `dram_we`=1, `dram_wdata`=42, `run_en`=1; `dram_write_ext` toggled during run -> no extra write.
- Out of range: `DRAM_DEPTH`=256, DRAM write at `addr_ext`=300 -> no `dram_we`, `oob_err`=1.
- Reset mid-write: assert `reset` in the cycle between the strobe edge and the write cycle -> `dram_we` never asserts; all outputs 0 after reset.
